// File: rtl/register_file_if.sv
// Decoder / ROB side bundle of the register file: operand lookup, commit port and ROB forwarding query.
// The register file itself takes the slave modport.
interface register_file_if #(
    parameter int REG_WIDTH = 5,
    parameter int ROB_WIDTH = 4
);
    logic                 dec_en;
    logic [REG_WIDTH-1:0] dec_rs1;
    logic [REG_WIDTH-1:0] dec_rs2;
    logic [REG_WIDTH-1:0] dec_rd;
    logic [ROB_WIDTH-1:0] dec_rob_id;
    logic [31:0]          dec_val_j;
    logic                 dec_dep_j;
    logic [ROB_WIDTH-1:0] dec_tag_j;
    logic [31:0]          dec_val_k;
    logic                 dec_dep_k;
    logic [ROB_WIDTH-1:0] dec_tag_k;
    logic                 flush;
    logic [REG_WIDTH-1:0] commit_reg_id;
    logic [31:0]          commit_data;
    logic [ROB_WIDTH-1:0] commit_rob_id;
    logic [ROB_WIDTH-1:0] reg_rob_id_j;
    logic                 reg_ready_j;
    logic [31:0]          reg_data_j;
    logic [ROB_WIDTH-1:0] reg_rob_id_k;
    logic                 reg_ready_k;
    logic [31:0]          reg_data_k;

    modport master (
        output dec_en, dec_rs1, dec_rs2, dec_rd, dec_rob_id,
        output flush, commit_reg_id, commit_data, commit_rob_id,
        output reg_ready_j, reg_data_j, reg_ready_k, reg_data_k,
        input  dec_val_j, dec_dep_j, dec_tag_j, dec_val_k, dec_dep_k, dec_tag_k,
        input  reg_rob_id_j, reg_rob_id_k
    );

    modport slave (
        input  dec_en, dec_rs1, dec_rs2, dec_rd, dec_rob_id,
        input  flush, commit_reg_id, commit_data, commit_rob_id,
        input  reg_ready_j, reg_data_j, reg_ready_k, reg_data_k,
        output dec_val_j, dec_dep_j, dec_tag_j, dec_val_k, dec_dep_k, dec_tag_k,
        output reg_rob_id_j, reg_rob_id_k
    );
endinterface

// File: rtl/register_file.sv
// Architectural register file with a register status table (busy + producing ROB tag) for the Tomasulo core.
// Operands resolve combinationally to a value or a pending tag; commits and renames update state at the clock edge.
module register_file #(
    parameter int REG_WIDTH = 5,
    parameter int ROB_WIDTH = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    register_file_if.slave    bus
);
    localparam int NUM_REGS = 2 ** REG_WIDTH;

    logic [31:0]          value_arr [NUM_REGS];
    logic                 busy_arr  [NUM_REGS];
    logic [ROB_WIDTH-1:0] tag_arr   [NUM_REGS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign value_arr[gi] = '0;
                assign busy_arr[gi]  = 1'b0;
                assign tag_arr[gi]   = '0;
            end else begin : g_live
                logic [31:0]          value_reg;
                logic                 busy_reg;
                logic [ROB_WIDTH-1:0] tag_reg;

                // Later assignments win: a same-cycle rename overrides the commit's busy clear.
                always_ff @(posedge clk_in) begin
                    if (rst_in) begin
                        value_reg <= '0;
                        busy_reg  <= 1'b0;
                        tag_reg   <= '0;
                    end else if (rdy_in) begin
                        if (bus.commit_reg_id == REG_WIDTH'(gi)) begin
                            value_reg <= bus.commit_data;
                            if (tag_reg == bus.commit_rob_id)
                                busy_reg <= 1'b0;
                        end
                        if (bus.flush) begin
                            busy_reg <= 1'b0;
                        end else if (bus.dec_en && bus.dec_rd == REG_WIDTH'(gi)) begin
                            busy_reg <= 1'b1;
                            tag_reg  <= bus.dec_rob_id;
                        end
                    end
                end

                assign value_arr[gi] = value_reg;
                assign busy_arr[gi]  = busy_reg;
                assign tag_arr[gi]   = tag_reg;
            end
        end
    endgenerate

    // Lookup always sees pre-update state, so rd==rs depends on the older producer.
    function automatic void resolve(
        input  logic [REG_WIDTH-1:0] rs,
        input  logic                 rob_ready,
        input  logic [31:0]          rob_data,
        output logic [31:0]          val,
        output logic                 dep
    );
        val = '0;
        dep = 1'b0;
        if (rs == '0) begin
            val = '0;
        end else if (!busy_arr[rs]) begin
            val = value_arr[rs];
        end else if (bus.commit_reg_id == rs && bus.commit_rob_id == tag_arr[rs]) begin
            val = bus.commit_data;
        end else if (rob_ready) begin
            val = rob_data;
        end else begin
            dep = 1'b1;
        end
    endfunction

    logic [31:0] val_j_next;
    logic [31:0] val_k_next;
    logic        dep_j_next;
    logic        dep_k_next;

    always_comb begin
        val_j_next = '0;
        val_k_next = '0;
        dep_j_next = 1'b0;
        dep_k_next = 1'b0;
        resolve(bus.dec_rs1, bus.reg_ready_j, bus.reg_data_j, val_j_next, dep_j_next);
        resolve(bus.dec_rs2, bus.reg_ready_k, bus.reg_data_k, val_k_next, dep_k_next);
    end

    assign bus.dec_val_j    = val_j_next;
    assign bus.dec_dep_j    = dep_j_next;
    assign bus.dec_tag_j    = tag_arr[bus.dec_rs1];
    assign bus.dec_val_k    = val_k_next;
    assign bus.dec_dep_k    = dep_k_next;
    assign bus.dec_tag_k    = tag_arr[bus.dec_rs2];
    assign bus.reg_rob_id_j = tag_arr[bus.dec_rs1];
    assign bus.reg_rob_id_k = tag_arr[bus.dec_rs2];
endmodule
